// File: rtl/display_pkg.sv
// Shared character codes, glyph table, message ROM and mode encodings for the
// four-digit scrolling seven-segment driver.
package display_pkg;

    typedef logic [4:0] char_t;

    localparam char_t CH_S     = 5'd10;
    localparam char_t CH_E     = 5'd11;
    localparam char_t CH_L     = 5'd12;
    localparam char_t CH_C     = 5'd13;
    localparam char_t CH_T     = 5'd14;
    localparam char_t CH_O     = 5'd15;
    localparam char_t CH_D     = 5'd16;
    localparam char_t CH_U     = 5'd17;
    localparam char_t CH_N     = 5'd18;
    localparam char_t CH_J     = 5'd19;
    localparam char_t CH_Y     = 5'd20;
    localparam char_t CH_BLANK = 5'd21;
    localparam char_t CH_DASH  = 5'd22;

    localparam logic [2:0] MODE_BLANK    = 3'd0;
    localparam logic [2:0] MODE_SELECT   = 3'd1;
    localparam logic [2:0] MODE_SOLD_OUT = 3'd3;
    localparam logic [2:0] MODE_ENJOY    = 3'd4;

    localparam int LEN_SELECT   = 6;
    localparam int LEN_SOLD_OUT = 8;
    localparam int LEN_ENJOY    = 5;

    typedef enum logic {
        CONV_IDLE,
        CONV_RUN
    } conv_state_t;

    // Active-low segments, bit0 = a ... bit6 = g.
    function automatic logic [6:0] glyph(input char_t c);
        logic [6:0] g;
        case (c)
            5'd0:    g = 7'h40;
            5'd1:    g = 7'h79;
            5'd2:    g = 7'h24;
            5'd3:    g = 7'h30;
            5'd4:    g = 7'h19;
            5'd5:    g = 7'h12;
            5'd6:    g = 7'h02;
            5'd7:    g = 7'h78;
            5'd8:    g = 7'h00;
            5'd9:    g = 7'h10;
            CH_S:    g = 7'h12;
            CH_E:    g = 7'h06;
            CH_L:    g = 7'h47;
            CH_C:    g = 7'h46;
            CH_T:    g = 7'h07;
            CH_O:    g = 7'h40;
            CH_D:    g = 7'h21;
            CH_U:    g = 7'h41;
            CH_N:    g = 7'h2B;
            CH_J:    g = 7'h61;
            CH_Y:    g = 7'h11;
            CH_DASH: g = 7'h3F;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // Character at position idx of the message preceded by four blanks;
    // anything past the end of the message reads as blank.
    function automatic char_t msg_char(input logic [2:0] mode, input logic [3:0] idx);
        logic [3:0] off;
        char_t c;
        c   = CH_BLANK;
        off = idx - 4'd4;
        if (idx >= 4'd4) begin
            case (mode)
                MODE_SELECT: begin
                    case (off)
                        4'd0:    c = CH_S;
                        4'd1:    c = CH_E;
                        4'd2:    c = CH_L;
                        4'd3:    c = CH_E;
                        4'd4:    c = CH_C;
                        4'd5:    c = CH_T;
                        default: c = CH_BLANK;
                    endcase
                end
                MODE_SOLD_OUT: begin
                    case (off)
                        4'd0:    c = CH_S;
                        4'd1:    c = CH_O;
                        4'd2:    c = CH_L;
                        4'd3:    c = CH_D;
                        4'd5:    c = CH_O;
                        4'd6:    c = CH_U;
                        4'd7:    c = CH_T;
                        default: c = CH_BLANK;
                    endcase
                end
                MODE_ENJOY: begin
                    case (off)
                        4'd0:    c = CH_E;
                        4'd1:    c = CH_N;
                        4'd2:    c = CH_J;
                        4'd3:    c = CH_O;
                        4'd4:    c = CH_Y;
                        default: c = CH_BLANK;
                    endcase
                end
                default: c = CH_BLANK;
            endcase
        end
        return c;
    endfunction

    // Last scroll position (L+3) before wrapping back to 0.
    function automatic logic [3:0] msg_last(input logic [2:0] mode);
        logic [3:0] last;
        case (mode)
            MODE_SELECT:   last = 4'(LEN_SELECT + 3);
            MODE_SOLD_OUT: last = 4'(LEN_SOLD_OUT + 3);
            MODE_ENJOY:    last = 4'(LEN_ENJOY + 3);
            default:       last = 4'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/seven_segment_scroll_driver_bcd.sv
// Serial 12-bit binary to 4-digit BCD converter (shift-add-3, one bit per cycle).
module bin_to_bcd_serial
    import display_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    conv_state_t state, state_n;
    logic [11:0] sr, sr_n;
    logic [15:0] acc, acc_n, adj;
    logic [3:0]  iter, iter_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CONV_IDLE;
            sr    <= '0;
            acc   <= '0;
            iter  <= '0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            acc   <= acc_n;
            iter  <= iter_n;
        end
    end

    always_comb begin
        adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // done and bcd are valid during the final iteration so the consumer can
    // latch the result on the same edge that completes the conversion.
    always_comb begin
        state_n = state;
        sr_n    = sr;
        acc_n   = acc;
        iter_n  = iter;
        done    = 1'b0;
        bcd     = {adj[14:0], sr[11]};
        busy    = (state == CONV_RUN);
        case (state)
            CONV_IDLE: begin
                if (start) begin
                    sr_n    = bin;
                    acc_n   = '0;
                    iter_n  = '0;
                    state_n = CONV_RUN;
                end
            end
            CONV_RUN: begin
                acc_n  = {adj[14:0], sr[11]};
                sr_n   = {sr[10:0], 1'b0};
                iter_n = iter + 4'd1;
                if (iter == 4'd11) begin
                    done    = 1'b1;
                    state_n = CONV_IDLE;
                end
            end
            default: state_n = CONV_IDLE;
        endcase
    end

endmodule

// File: rtl/seven_segment_scroll_driver.sv
// Four-digit multiplexed seven-segment driver: money readout or scrolling text.
module seven_segment_scroll_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50_000,
    parameter int SCROLL_DIV  = 15_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  scrollMode,
    input  logic        showMoney,
    input  logic [11:0] amountDisplay,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [RW-1:0] refresh_cnt;
    logic [SW-1:0] scroll_cnt;
    logic [1:0]    digit;
    logic [3:0]    pos;
    logic [2:0]    mode_q;
    logic          show_q;
    logic [11:0]   captured;
    logic [15:0]   bcd_disp;

    logic          conv_start, conv_busy, conv_done;
    logic [15:0]   conv_bcd;
    logic          refresh_wrap, scroll_wrap, scrolling, restart;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [3:0]    an_n, an_sel, win_idx, nib;

    assign conv_start   = !conv_busy && (amountDisplay != captured);
    assign refresh_wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));
    assign scroll_wrap  = (scroll_cnt == SW'(SCROLL_DIV - 1));
    assign scrolling    = !showMoney && (scrollMode == MODE_SELECT ||
                                         scrollMode == MODE_SOLD_OUT ||
                                         scrollMode == MODE_ENJOY);
    assign restart      = (scrollMode != mode_q) || (show_q && !showMoney);

    bin_to_bcd_serial u_bcd (
        .clock (clock),
        .reset (reset),
        .start (conv_start),
        .bin   (amountDisplay),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            refresh_cnt <= '0;
            scroll_cnt  <= '0;
            digit       <= 2'd3;
            pos         <= '0;
            mode_q      <= '0;
            show_q      <= 1'b0;
            captured    <= '0;
            bcd_disp    <= '0;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            an          <= 4'hF;
        end else begin
            refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
            if (refresh_wrap) digit <= digit - 2'd1;
            mode_q <= scrollMode;
            show_q <= showMoney;
            // A restart takes priority over a scroll step landing on the same edge.
            if (restart) begin
                pos        <= '0;
                scroll_cnt <= '0;
            end else if (scrolling) begin
                if (scroll_wrap) begin
                    scroll_cnt <= '0;
                    pos        <= (pos >= msg_last(scrollMode)) ? 4'd0 : pos + 4'd1;
                end else begin
                    scroll_cnt <= scroll_cnt + 1'b1;
                end
            end
            if (conv_start) captured <= amountDisplay;
            if (conv_done) bcd_disp <= conv_bcd;
            seg <= seg_n;
            dp  <= dp_n;
            an  <= an_n;
        end
    end

    always_comb begin
        an_sel        = 4'hF;
        an_sel[digit] = 1'b0;
        seg_n   = 7'h7F;
        dp_n    = 1'b1;
        an_n    = an_sel;
        nib     = bcd_disp[{digit, 2'b00} +: 4];
        win_idx = pos + {2'b00, ~digit};
        if (showMoney) begin
            seg_n = (digit == 2'd3 && nib == 4'd0) ? 7'h7F : glyph({1'b0, nib});
            dp_n  = (digit != 2'd2);
        end else if (scrollMode == MODE_BLANK) begin
            an_n = 4'hF;
        end else if (scrolling) begin
            seg_n = glyph(msg_char(scrollMode, win_idx));
        end else begin
            seg_n = glyph(CH_DASH);
        end
    end

endmodule

// File: tb/tb_seven_segment_scroll_driver.sv
// Bench for seven_segment_scroll_driver with short refresh/scroll dividers;
// expected per-cycle display frames are queued and compared against the pins.
module tb_seven_segment_scroll_driver;

    localparam int REFRESH_DIV = 4;
    localparam int SCROLL_DIV  = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  scrollMode;
    logic        showMoney;
    logic [11:0] amountDisplay;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    seven_segment_scroll_driver #(
        .REFRESH_DIV (REFRESH_DIV),
        .SCROLL_DIV  (SCROLL_DIV)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .scrollMode    (scrollMode),
        .showMoney     (showMoney),
        .amountDisplay (amountDisplay),
        .seg           (seg),
        .dp            (dp),
        .an            (an)
    );

    function automatic logic [6:0] glyph_of(input byte c);
        case (c)
            "0": return 7'h40;  "1": return 7'h79;  "2": return 7'h24;
            "3": return 7'h30;  "4": return 7'h19;  "5": return 7'h12;
            "6": return 7'h02;  "7": return 7'h78;  "8": return 7'h00;
            "9": return 7'h10;  "S": return 7'h12;  "E": return 7'h06;
            "L": return 7'h47;  "C": return 7'h46;  "T": return 7'h07;
            "O": return 7'h40;  "D": return 7'h21;  "U": return 7'h41;
            "N": return 7'h2B;  "J": return 7'h61;  "Y": return 7'h11;
            "-": return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    // Frame byte d holds {dp, seg} for digit d; c3 is the leftmost character.
    function automatic logic [31:0] frame4(input byte c3, input byte c2, input byte c1,
                                           input byte c0, input int dp_digit);
        byte c[4];
        logic [31:0] f;
        c[3] = c3; c[2] = c2; c[1] = c1; c[0] = c0;
        f = '0;
        for (int d = 0; d < 4; d++)
            f[d*8 +: 8] = {(d == dp_digit) ? 1'b0 : 1'b1, glyph_of(c[d])};
        return f;
    endfunction

    function automatic logic [31:0] money_frame(input int v);
        int d3;
        byte c3;
        d3 = (v / 1000) % 10;
        c3 = (d3 == 0) ? 8'h20 : byte'(8'h30 + d3);
        return frame4(c3, byte'(8'h30 + (v / 100) % 10), byte'(8'h30 + (v / 10) % 10),
                      byte'(8'h30 + v % 10), 2);
    endfunction

    function automatic logic [31:0] text_frame(input int mode, input int p);
        string msg;
        byte c[4];
        int idx;
        if (mode == 1)      msg = "SELECT";
        else if (mode == 3) msg = "SOLD OUT";
        else if (mode == 4) msg = "ENJOY";
        else                msg = "";
        for (int d = 0; d < 4; d++) begin
            idx = p + 3 - d;
            if (idx < 4 || idx - 4 >= msg.len()) c[d] = 8'h20;
            else c[d] = msg[idx-4];
        end
        return frame4(c[3], c[2], c[1], c[0], -1);
    endfunction

    // Monitor: advance to the next sampling point and report which digit is lit.
    task automatic sample_pins(output int d, output logic [7:0] obs);
        @(negedge clock);
        case (an)
            4'b0111: d = 3;
            4'b1011: d = 2;
            4'b1101: d = 1;
            4'b1110: d = 0;
            default: d = -1;
        endcase
        obs = {dp, seg};
    endtask

    task automatic test_reset();
        int d;
        logic [7:0] obs;
        reset = 1'b1; showMoney = 1'b1; scrollMode = 3'd0; amountDisplay = 12'd0;
        for (int i = 0; i < 3; i++) begin
            sample_pins(d, obs);
            compared++;
            if (an !== 4'hF || obs !== 8'hFF) begin
                mismatched++;
                $display("FAIL reset_hold: an=%b dp/seg=%h, want an=1111 dp/seg=ff", an, obs);
            end
        end
        reset = 1'b0;
        sample_pins(d, obs);
        compared++;
        if (an !== 4'b0111) begin
            mismatched++;
            $display("FAIL reset_first_anode: an=%b, want 0111", an);
        end
    endtask

    task automatic test_money();
        int d;
        logic [7:0] obs;
        logic [31:0] e;
        logic [3:0] prev, want;
        bit found;
        amountDisplay = 12'd250;
        for (int k = 14; k < 30; k++) exp_q.push_back(money_frame(250));
        for (int k = 1; k < 30; k++) begin
            sample_pins(d, obs);
            if (k >= 14) begin
                e = exp_q.pop_front();
                compared++;
                if (d < 0 || obs !== e[(d < 0 ? 0 : d)*8 +: 8]) begin
                    mismatched++;
                    $display("FAIL money_250 k=%0d: an=%b dp/seg=%h, want %h", k, an, obs,
                             e[(d < 0 ? 0 : d)*8 +: 8]);
                end
            end
        end
        prev = an;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (an == 4'b0111 && prev != 4'b0111) found = 1'b1;
            prev = an;
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL scan_start: timeout waiting for an=0111, got %b", an);
        end else begin
            for (int i = 1; i < 16; i++) begin
                @(negedge clock);
                want = ~(4'b1000 >> (i / 4));
                compared++;
                if (an !== want) begin
                    mismatched++;
                    $display("FAIL scan_order i=%0d: an=%b, want %b", i, an, want);
                end
            end
        end
    endtask

    task automatic test_change_mid_conversion();
        int d;
        logic [7:0] obs;
        logic [31:0] e;
        amountDisplay = 12'd4095;
        for (int k = 1; k <= 30; k++)
            exp_q.push_back(money_frame(k < 14 ? 250 : (k < 27 ? 4095 : 1)));
        for (int k = 1; k <= 30; k++) begin
            sample_pins(d, obs);
            if (k == 4) amountDisplay = 12'd1;
            e = exp_q.pop_front();
            compared++;
            if (d < 0 || obs !== e[(d < 0 ? 0 : d)*8 +: 8]) begin
                mismatched++;
                $display("FAIL mid_change k=%0d: an=%b dp/seg=%h, want %h", k, an, obs,
                         e[(d < 0 ? 0 : d)*8 +: 8]);
            end
        end
    endtask

    task automatic test_reset_mid_conversion();
        int d;
        logic [7:0] obs;
        logic [31:0] e;
        amountDisplay = 12'd999;
        for (int k = 7; k <= 35; k++) exp_q.push_back(money_frame(k < 20 ? 0 : 999));
        for (int k = 1; k <= 35; k++) begin
            sample_pins(d, obs);
            if (k == 5) reset = 1'b1;
            if (k == 6) begin
                reset = 1'b0;
                compared++;
                if (an !== 4'hF || obs !== 8'hFF) begin
                    mismatched++;
                    $display("FAIL reset_mid: an=%b dp/seg=%h, want 1111/ff", an, obs);
                end
            end
            if (k >= 7) begin
                e = exp_q.pop_front();
                compared++;
                if (d < 0 || obs !== e[(d < 0 ? 0 : d)*8 +: 8]) begin
                    mismatched++;
                    $display("FAIL after_reset_conv k=%0d: an=%b dp/seg=%h, want %h", k, an,
                             obs, e[(d < 0 ? 0 : d)*8 +: 8]);
                end
            end
        end
    endtask

    task automatic test_scroll();
        int d;
        logic [7:0] obs;
        logic [31:0] e;
        showMoney = 1'b0; scrollMode = 3'd4;
        for (int k = 2; k <= 162; k++) exp_q.push_back(text_frame(4, ((k - 2) / 16) % 9));
        for (int k = 1; k <= 162; k++) begin
            sample_pins(d, obs);
            if (k >= 2) begin
                e = exp_q.pop_front();
                compared++;
                if (d < 0 || obs !== e[(d < 0 ? 0 : d)*8 +: 8]) begin
                    mismatched++;
                    $display("FAIL scroll_enjoy k=%0d: an=%b dp/seg=%h, want %h", k, an, obs,
                             e[(d < 0 ? 0 : d)*8 +: 8]);
                end
            end
        end
    endtask

    task automatic test_mode_change();
        int d;
        logic [7:0] obs;
        logic [31:0] e;
        scrollMode = 3'd1;
        for (int k = 2; k <= 85; k++) exp_q.push_back(text_frame(1, ((k - 2) / 16) % 10));
        for (int k = 1; k <= 85; k++) begin
            sample_pins(d, obs);
            if (k >= 2) begin
                e = exp_q.pop_front();
                compared++;
                if (d < 0 || obs !== e[(d < 0 ? 0 : d)*8 +: 8]) begin
                    mismatched++;
                    $display("FAIL scroll_select k=%0d: an=%b dp/seg=%h, want %h", k, an, obs,
                             e[(d < 0 ? 0 : d)*8 +: 8]);
                end
            end
        end
        scrollMode = 3'd3;
        for (int j = 2; j <= 209; j++) exp_q.push_back(text_frame(3, ((j - 2) / 16) % 12));
        for (int j = 1; j <= 209; j++) begin
            sample_pins(d, obs);
            if (j >= 2) begin
                e = exp_q.pop_front();
                compared++;
                if (d < 0 || obs !== e[(d < 0 ? 0 : d)*8 +: 8]) begin
                    mismatched++;
                    $display("FAIL scroll_sold_out j=%0d: an=%b dp/seg=%h, want %h", j, an,
                             obs, e[(d < 0 ? 0 : d)*8 +: 8]);
                end
            end
        end
    endtask

    task automatic test_static_and_blank();
        int d;
        logic [7:0] obs;
        logic [31:0] e;
        scrollMode = 3'd2;
        for (int j = 1; j <= 40; j++) exp_q.push_back(frame4("-", "-", "-", "-", -1));
        for (int j = 1; j <= 40; j++) begin
            sample_pins(d, obs);
            e = exp_q.pop_front();
            compared++;
            if (d < 0 || obs !== e[(d < 0 ? 0 : d)*8 +: 8]) begin
                mismatched++;
                $display("FAIL static_dash j=%0d: an=%b dp/seg=%h, want %h", j, an, obs,
                         e[(d < 0 ? 0 : d)*8 +: 8]);
            end
        end
        scrollMode = 3'd0;
        for (int j = 1; j <= 20; j++) begin
            sample_pins(d, obs);
            compared++;
            if (an !== 4'hF || obs !== 8'hFF) begin
                mismatched++;
                $display("FAIL blank_mode j=%0d: an=%b dp/seg=%h, want 1111/ff", j, an, obs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_money();
        test_change_mid_conversion();
        test_reset_mid_conversion();
        test_scroll();
        test_mode_change();
        test_static_and_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seven_segment_scroll_driver.md
# seven_segment_scroll_driver

Drives the four-digit multiplexed seven-segment display from the display controller's abstract outputs (`scrollMode`, `showMoney`, `amountDisplay`). It renders scrolling text messages or a decimal money amount, and converts the 12-bit binary amount to BCD serially. It time-multiplexes the digit anodes. It sits directly downstream of the display controller and directly drives the board's segment and anode pins.

## Interface
Parameters:
- `REFRESH_DIV`, default 50_000: clock cycles per digit slot (1 kHz digit rate at 50 MHz).
- `SCROLL_DIV`, default 15_000_000: clock cycles per scroll step (0.3 s at 50 MHz).

Ports:
- `clock`, in, 1: single system clock (50 MHz).
- `reset`, in, 1: synchronous, active-high reset.
- `scrollMode`, in, 3: message select. 0 = blank, 1 = "SELECT", 3 = "SOLD OUT", 4 = "ENJOY", 2/5/6/7 = static "----".
- `showMoney`, in, 1: when 1, display the amount; `scrollMode` is ignored.
- `amountDisplay`, in, 12: binary amount in cents, 0..4095.
- `seg`, out, 7: active-low segments; bit0 = a … bit6 = g.
- `dp`, out, 1: active-low decimal point.
- `an`, out, 4: active-low anodes; `an[3]` is the leftmost digit.

## Operation
- **Digit scan:** a refresh counter counts 0..`REFRESH_DIV`-1. On wrap, the 2-bit digit index advances 3→2→1→0→3 (leftmost first).
  - Only the indexed digit's anode is low, except in the blank case below.
- **Money mode** (`showMoney`=1):
  - Display the four BCD digits of the last completed conversion, formatted as "d.dd" in cents.
  - `dp` is low on digit 2 only.
  - Digit 3 is blanked (all segments high) when its BCD value is 0.
  - Example: 250 → " 2.50"; 4095 → "40.95"; 0 → " 0.00".
- **BCD conversion:**
  - A conversion starts when idle and `amountDisplay` ≠ the last-captured value.
  - It captures the input and runs 12 shift-add-3 iterations, one per cycle.
  - The displayed BCD register updates in a single cycle at completion.
  - An input change during a conversion is not aborted: the current conversion finishes, then a new one starts on the next idle cycle.
- **Text mode** (`showMoney`=0):
  - The message is padded with 4 leading blanks, giving a sequence of length L+4.
  - The window shows sequence chars [pos..pos+3]; char pos is on the leftmost digit.
  - A scroll counter counts 0..`SCROLL_DIV`-1. On wrap, pos increments; pos wraps from L+3 to 0. Text enters from the right.
  - Message lengths L: "SELECT" = 6, "SOLD OUT" = 8 (includes one blank), "ENJOY" = 5.
  - Mode 0: all anodes high.
  - "----" modes: static, no scrolling, g segment only on every digit.
- **Restart:** any change of `scrollMode`, or a 1→0 transition of `showMoney`, clears pos and the scroll counter on the next edge. The refresh scan is unaffected.
- **Reset values:**
  - `seg`=7'h7F, `dp`=1, `an`=4'hF.
  - Digit index=3, pos=0, both counters=0.
  - BCD register=0, converter idle, captured value=0.

## Timing
- `seg`, `dp`, and `an` are registered: they reflect the digit index, inputs, and pos of the previous cycle (1-cycle latency). No combinational path runs from inputs to pins.
- BCD latency from an `amountDisplay` change to the display register: 13 cycles (1 capture + 12 iterations). The pins follow 1 cycle later.
- A scroll step and a mode change in the same cycle: the mode change wins (pos=0).
- A `reset` assertion mid-scan or mid-conversion: all state returns to reset values on that edge, and any partial conversion is discarded.
- All counters are sized by `$clog2` of their parameter.

## Structure
- Shared package `display_pkg` holds:
  - the 5-bit character codes: digits 0–9, S, E, L, C, T, O, D, U, N, J, Y, BLANK, DASH;
  - the 7-bit active-low glyph table;
  - the scrollMode encodings;
  - the message length constants.
- One sub-module, `bin_to_bcd_serial`. Interface: `clock`, `reset`, `start`, 12-bit `bin`, `busy`, `done` pulse, 16-bit `bcd`.
- Message ROM and glyph lookup are combinational functions in the package.

## Test plan
Run with `REFRESH_DIV`=4 and `SCROLL_DIV`=16.
- **Reset:** assert `reset` for 3 cycles → `seg`=7'h7F, `dp`=1, `an`=4'hF throughout; after release, the first active anode is `an`=4'b0111.
- **Money display:** `showMoney`=1, `amountDisplay`=250 → after 14 cycles, one full scan shows digit3 blank, digit2 "2" with `dp`=0, digit1 "5", digit0 "0"; `an` cycles 0111→1011→1101→1110 every 4 cycles.
- **Amount change mid-conversion:** change 4095 → 1 at cycle 5 of a conversion → display shows "40.95" first, then " 0.01" within 27 cycles of the first change.
- **Scroll:** `scrollMode`=4 → pos steps every 16 cycles; at pos=4 the display reads "ENJO"; at pos=8 it reads "Y" plus 3 blanks; pos wraps to 0 after pos=8.
- **Mode change:** switch from `scrollMode`=1 at pos=5 to `scrollMode`=3 → pos=0 next cycle, display all blank; "SOLD OUT" cycle length is 12 steps.
- **Static and blank modes:** `scrollMode`=2 → every digit `seg`=7'b0111111, no scroll advance; `scrollMode`=0 → `an`=4'hF.
